decode_cycle: RTL and testbench
===============================

// Module: decode_cycle
// PURPOSE
//  RV32I ID stage. Sits downstream of the fetch stage's IF/ID register (instr/pc/pc_4).
//  Decodes the instruction, reads the 32x32 register file, extends the immediate and
//  registers everything into the ID/EX pipeline register. Also accepts the WB-stage
//  register write.
// PARAMETERS
//  XLEN      32  datapath width
//  NUM_REGS  32  architectural registers; x0 is hardwired to 0
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   synchronous, active-high reset
//  instr_d      in   32  instruction from IF/ID
//  pc_d         in   32  PC of instr_d
//  pc_4_d       in   32  pc_d+4
//  stall_d      in   1   hold the ID/EX register (hazard unit)
//  flush_e      in   1   load a bubble into ID/EX (branch taken / load-use)
//  reg_write_w  in   1   WB register write enable
//  rd_w         in   5   WB destination register
//  result_w     in   32  WB write data
//  rs1_d,rs2_d  out  5   combinational source fields, to the hazard unit
//  rd1_e,rd2_e  out  32  registered operands
//  imm_ext_e    out  32  registered extended immediate
//  rs1_e,rs2_e,rd_e  out 5  registered register indices
//  pc_e,pc_4_e  out  32  registered PC, PC+4
//  reg_write_e,mem_write_e,jump_e,branch_e,alu_src_b_e,illegal_e  out 1  registered controls
//  alu_a_src_e  out  2   00=rs1, 01=pc, 10=zero
//  result_src_e out  2   00=ALU, 01=mem, 10=pc+4
//  alu_ctrl_e   out  4   rv32i_pkg::alu_op_t
//  funct3_e     out  3   branch/load/store type
// BEHAVIOUR
//  - Latency: 1 cycle from instr_d to the *_e outputs. The ID/EX update priority is
//    rst > flush_e > stall_d > load.
//  - rst: every *_e output = 0 (bubble) and all regfile entries = 0.
//  - flush_e: every *_e output = 0 on the next edge. Flush overrides a simultaneous stall.
//  - stall_d (no flush): all *_e outputs hold their values.
//  - Regfile write: on posedge clk when reg_write_w && rd_w!=0. Writes to x0 are dropped,
//    and the write proceeds even while stall_d is asserted.
//  - Regfile read: combinational. A read of x0 always returns 0.
//  - Decode by opcode:
//      LUI     -> a=zero, imm U
//      AUIPC   -> a=pc, imm U
//      JAL     -> jump, src pc+4, imm J
//      JALR    -> jump, src pc+4, imm I, a=rs1
//      BRANCH  -> branch, imm B, alu SUB/SLT/SLTU selected by funct3
//      LOAD    -> src mem, imm I
//      STORE   -> mem_write, imm S
//      OP-IMM / OP -> ALU op from funct3 (+funct7[5] for SUB/SRA; for OP-IMM only on shifts)
//      FENCE / SYSTEM -> NOP (all controls 0)
//  - Immediates are sign-extended from instr[31]. B and J immediates have bit0=0.
//  - instr_d==0 -> bubble with illegal_e=0. Any other undefined opcode/funct -> controls 0,
//    illegal_e=1.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: a same-cycle WB write to rs1/rs2 (rd_w!=0) is forwarded
//    combinationally to the read data (write-first).
//  Not defined: the read returns the old value, and the hazard unit must stall one extra
//    cycle on a WB->ID dependency.
// STRUCTURE
//  rv32i_pkg holds:
//    - opcode localparams
//    - alu_op_t enum (ADD,SUB,AND,OR,XOR,SLL,SRL,SRA,SLT,SLTU)
//    - imm_t enum (I,S,B,U,J)
//    - result_src and alu_a_src encodings
//  Sub-module register_file: 2 read ports, 1 write port, sync reset, bypass under the macro.
//  Decoder and immediate extension are combinational inside decode_cycle.
// TESTING
//  1. addi x1,x0,5 (0x00500093) -> next cycle: reg_write_e=1, alu_src_b_e=1,
//     alu_ctrl_e=ADD, imm_ext_e=5, rd_e=1.
//  2. WB write x3=0xDEADBEEF, then decode add x4,x3,x0 -> rd1_e=0xDEADBEEF.
//     Same-cycle case: 0xDEADBEEF with the macro, 0 without it.
//  3. reg_write_w=1, rd_w=0, result_w=7, then read x0 -> rd1_e=0.
//  4. beq with imm -8 (0xFE000CE3) -> branch_e=1, imm_ext_e=0xFFFFFFF8.
//     jal x1,+2048 -> jump_e=1, result_src_e=10, imm_ext_e=0x00000800.
//  5. Load lw, then assert stall_d 2 cycles -> outputs hold.
//     stall_d+flush_e together -> all *_e = 0. Mid-stream rst -> all *_e = 0 and
//     regfile cleared.
//  6. opcode 0x7F -> illegal_e=1, reg_write_e=0, mem_write_e=0. instr_d=0 -> illegal_e=0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation and immediate-format enums,
// operand/result mux encodings and the funct3 -> ALU operation mapping.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_t;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] A_RS1  = 2'b00;
    localparam logic [1:0] A_PC   = 2'b01;
    localparam logic [1:0] A_ZERO = 2'b10;

    // alt selects SUB over ADD and SRA over SRL (instr[30] when it applies)
    function automatic alu_op_t alu_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/register_file.sv
// 2-read/1-write register file with x0 hardwired to zero and synchronous clear.
// Optional REGFILE_BYPASS_EN: same-cycle write data is forwarded to the read ports (write-first).
module register_file
    import rv32i_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic [XLEN-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we && (wa != '0)) begin
            regs_d[wa] = wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign rd1 = (ra1 == '0) ? '0 : ((we && (wa == ra1)) ? wd : regs_q[ra1]);
    assign rd2 = (ra2 == '0) ? '0 : ((we && (wa == ra2)) ? wd : regs_q[ra2]);
`else
    assign rd1 = (ra1 == '0) ? '0 : regs_q[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs_q[ra2];
`endif

endmodule

// File: rtl/decode_cycle.sv
// RV32I ID stage: decode, register read, immediate extension and the ID/EX register.
// Optional REGFILE_BYPASS_EN forwards a same-cycle WB write into the operand read.
module decode_cycle
    import rv32i_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pc_4_d,
    input  logic            stall_d,
    input  logic            flush_e,
    input  logic            reg_write_w,
    input  logic [4:0]      rd_w,
    input  logic [XLEN-1:0] result_w,
    output logic [4:0]      rs1_d,
    output logic [4:0]      rs2_d,
    output logic [XLEN-1:0] rd1_e,
    output logic [XLEN-1:0] rd2_e,
    output logic [XLEN-1:0] imm_ext_e,
    output logic [4:0]      rs1_e,
    output logic [4:0]      rs2_e,
    output logic [4:0]      rd_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] pc_4_e,
    output logic            reg_write_e,
    output logic            mem_write_e,
    output logic            jump_e,
    output logic            branch_e,
    output logic            alu_src_b_e,
    output logic            illegal_e,
    output logic [1:0]      alu_a_src_e,
    output logic [1:0]      result_src_e,
    output alu_op_t         alu_ctrl_e,
    output logic [2:0]      funct3_e
);

    typedef struct packed {
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm_ext;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_4;
        logic            reg_write;
        logic            mem_write;
        logic            jump;
        logic            branch;
        logic            alu_src_b;
        logic            illegal;
        logic [1:0]      alu_a_src;
        logic [1:0]      result_src;
        alu_op_t         alu_ctrl;
        logic [2:0]      funct3;
    } idex_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;

    assign opcode = instr_d[6:0];
    assign funct3 = instr_d[14:12];
    assign funct7 = instr_d[31:25];
    assign rs1_d  = instr_d[19:15];
    assign rs2_d  = instr_d[24:20];

    register_file #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS)
    ) u_register_file (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1_d),
        .ra2 (rs2_d),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2),
        .we  (reg_write_w),
        .wa  (rd_w),
        .wd  (result_w)
    );

    logic        legal;
    logic        imm_en;
    imm_t        imm_sel;
    logic        reg_write, mem_write, jump, branch, alu_src_b;
    logic [1:0]  alu_a_src, result_src;
    alu_op_t     alu_ctrl;

    always_comb begin
        legal      = 1'b1;
        imm_en     = 1'b0;
        imm_sel    = IMM_I;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        alu_src_b  = 1'b0;
        alu_a_src  = A_RS1;
        result_src = RES_ALU;
        alu_ctrl   = ALU_ADD;
        case (opcode)
            OPC_LUI: begin
                reg_write = 1'b1; alu_src_b = 1'b1; alu_a_src = A_ZERO;
                imm_en = 1'b1; imm_sel = IMM_U;
            end
            OPC_AUIPC: begin
                reg_write = 1'b1; alu_src_b = 1'b1; alu_a_src = A_PC;
                imm_en = 1'b1; imm_sel = IMM_U;
            end
            OPC_JAL: begin
                reg_write = 1'b1; jump = 1'b1; result_src = RES_PC4;
                alu_src_b = 1'b1; alu_a_src = A_PC; imm_en = 1'b1; imm_sel = IMM_J;
            end
            OPC_JALR: begin
                legal = (funct3 == 3'b000);
                reg_write = 1'b1; jump = 1'b1; result_src = RES_PC4;
                alu_src_b = 1'b1; imm_en = 1'b1; imm_sel = IMM_I;
            end
            OPC_BRANCH: begin
                legal  = (funct3[2:1] != 2'b01);
                branch = 1'b1; imm_en = 1'b1; imm_sel = IMM_B;
                alu_ctrl = !funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
            end
            OPC_LOAD: begin
                legal = (funct3 != 3'b011) && (funct3 < 3'b110);
                reg_write = 1'b1; result_src = RES_MEM; alu_src_b = 1'b1;
                imm_en = 1'b1; imm_sel = IMM_I;
            end
            OPC_STORE: begin
                legal = (funct3 <= 3'b010);
                mem_write = 1'b1; alu_src_b = 1'b1; imm_en = 1'b1; imm_sel = IMM_S;
            end
            OPC_OP_IMM: begin
                // only the shifts carry a funct7; elsewhere instr[31:25] is immediate
                if (funct3 == 3'b001) begin
                    legal = (funct7 == 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                end
                reg_write = 1'b1; alu_src_b = 1'b1; imm_en = 1'b1; imm_sel = IMM_I;
                alu_ctrl  = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
            end
            OPC_OP: begin
                legal = (funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                reg_write = 1'b1;
                alu_ctrl  = alu_from_funct3(funct3, funct7[5]);
            end
            OPC_FENCE, OPC_SYSTEM: begin
                legal = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    logic signed [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_sel)
            IMM_I:   imm32 = {{20{instr_d[31]}}, instr_d[31:20]};
            IMM_S:   imm32 = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
            IMM_B:   imm32 = {{19{instr_d[31]}}, instr_d[31], instr_d[7],
                              instr_d[30:25], instr_d[11:8], 1'b0};
            IMM_U:   imm32 = {instr_d[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr_d[31]}}, instr_d[31], instr_d[19:12],
                              instr_d[20], instr_d[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    idex_t dec;

    always_comb begin
        dec        = '0;
        dec.rd1    = rf_rd1;
        dec.rd2    = rf_rd2;
        dec.rs1    = rs1_d;
        dec.rs2    = rs2_d;
        dec.rd     = instr_d[11:7];
        dec.pc     = pc_d;
        dec.pc_4   = pc_4_d;
        dec.funct3 = funct3;
        if (instr_d == 32'h0) begin
            dec = '0;
        end else if (!legal) begin
            dec.illegal = 1'b1;
        end else begin
            dec.reg_write  = reg_write;
            dec.mem_write  = mem_write;
            dec.jump       = jump;
            dec.branch     = branch;
            dec.alu_src_b  = alu_src_b;
            dec.alu_a_src  = alu_a_src;
            dec.result_src = result_src;
            dec.alu_ctrl   = alu_ctrl;
            dec.imm_ext    = imm_en ? XLEN'(imm32) : '0;
        end
    end

    // ID/EX register: flush beats stall; reset is handled in the flop itself
    idex_t idex_d, idex_q;

    always_comb begin
        idex_d = idex_q;
        if (flush_e) begin
            idex_d = '0;
        end else if (!stall_d) begin
            idex_d = dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign rd1_e        = idex_q.rd1;
    assign rd2_e        = idex_q.rd2;
    assign imm_ext_e    = idex_q.imm_ext;
    assign rs1_e        = idex_q.rs1;
    assign rs2_e        = idex_q.rs2;
    assign rd_e         = idex_q.rd;
    assign pc_e         = idex_q.pc;
    assign pc_4_e       = idex_q.pc_4;
    assign reg_write_e  = idex_q.reg_write;
    assign mem_write_e  = idex_q.mem_write;
    assign jump_e       = idex_q.jump;
    assign branch_e     = idex_q.branch;
    assign alu_src_b_e  = idex_q.alu_src_b;
    assign illegal_e    = idex_q.illegal;
    assign alu_a_src_e  = idex_q.alu_a_src;
    assign result_src_e = idex_q.result_src;
    assign alu_ctrl_e   = idex_q.alu_ctrl;
    assign funct3_e     = idex_q.funct3;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed and randomized bench for decode_cycle against a behavioural ID-stage model.
module tb_decode_cycle;
    import rv32i_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] instr_d, pc_d, pc_4_d;
    logic        stall_d, flush_e, reg_write_w;
    logic [4:0]  rd_w;
    logic [31:0] result_w;
    logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
    logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_4_e;
    logic        reg_write_e, mem_write_e, jump_e, branch_e, alu_src_b_e, illegal_e;
    logic [1:0]  alu_a_src_e, result_src_e;
    alu_op_t     alu_ctrl_e;
    logic [2:0]  funct3_e;

    decode_cycle dut (
        .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d(pc_d), .pc_4_d(pc_4_d),
        .stall_d(stall_d), .flush_e(flush_e), .reg_write_w(reg_write_w), .rd_w(rd_w),
        .result_w(result_w), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd1_e(rd1_e), .rd2_e(rd2_e),
        .imm_ext_e(imm_ext_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .pc_e(pc_e),
        .pc_4_e(pc_4_e), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
        .jump_e(jump_e), .branch_e(branch_e), .alu_src_b_e(alu_src_b_e),
        .illegal_e(illegal_e), .alu_a_src_e(alu_a_src_e), .result_src_e(result_src_e),
        .alu_ctrl_e(alu_ctrl_e), .funct3_e(funct3_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] pc, pc4;
        logic        reg_write, mem_write, jump, branch, alu_src_b, illegal;
        logic [1:0]  a_src, res_src;
        logic [3:0]  alu;
        logic [2:0]  f3;
    } out_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] rf [32];
    out_t        exp_q;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic out_t dut_now();
        out_t o;
        o = '{rd1_e, rd2_e, imm_ext_e, rs1_e, rs2_e, rd_e, pc_e, pc_4_e, reg_write_e,
              mem_write_e, jump_e, branch_e, alu_src_b_e, illegal_e, alu_a_src_e,
              result_src_e, alu_ctrl_e, funct3_e};
        return o;
    endfunction

    function automatic logic [31:0] rf_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (reg_write_w && rd_w == a) return result_w;
`endif
        return rf[a];
    endfunction

    // Reference decoder built directly from the RV32I encoding rules
    function automatic out_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                          input logic [31:0] pc4, input logic [31:0] r1,
                                          input logic [31:0] r2);
        out_t    o;
        bit      ok;
        alu_op_t tbl [8];
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
        tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        o  = '0;
        ok = 1;
        if (ins == 32'h0) return o;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        i_imm = 32'($signed(ins[31:20]));
        s_imm = 32'($signed({ins[31:25], ins[11:7]}));
        b_imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        u_imm = ins[31:12] * 32'd4096;
        j_imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        o.rd1 = r1; o.rd2 = r2; o.rs1 = ins[19:15]; o.rs2 = ins[24:20]; o.rd = ins[11:7];
        o.pc = pc; o.pc4 = pc4; o.f3 = f3;
        case (op)
            7'h37: begin o.reg_write = 1; o.a_src = 2; o.alu_src_b = 1; o.imm = u_imm; end
            7'h17: begin o.reg_write = 1; o.a_src = 1; o.alu_src_b = 1; o.imm = u_imm; end
            7'h6F: begin o.reg_write = 1; o.jump = 1; o.res_src = 2; o.a_src = 1;
                         o.alu_src_b = 1; o.imm = j_imm; end
            7'h67: begin ok = (f3 == 0); o.reg_write = 1; o.jump = 1; o.res_src = 2;
                         o.alu_src_b = 1; o.imm = i_imm; end
            7'h63: begin ok = (f3 != 2 && f3 != 3); o.branch = 1; o.imm = b_imm;
                         o.alu = (f3 < 4) ? ALU_SUB : ((f3 >= 6) ? ALU_SLTU : ALU_SLT); end
            7'h03: begin ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
                         o.reg_write = 1; o.res_src = 1; o.alu_src_b = 1; o.imm = i_imm; end
            7'h23: begin ok = (f3 <= 2); o.mem_write = 1; o.alu_src_b = 1; o.imm = s_imm; end
            7'h13: begin
                o.reg_write = 1; o.alu_src_b = 1; o.imm = i_imm; o.alu = tbl[f3];
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) begin
                    ok = (f7 == 0 || f7 == 7'h20);
                    if (f7 == 7'h20) o.alu = ALU_SRA;
                end
            end
            7'h33: begin
                o.reg_write = 1; o.alu = tbl[f3];
                ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                if (f7 == 7'h20 && f3 == 0) o.alu = ALU_SUB;
                if (f7 == 7'h20 && f3 == 5) o.alu = ALU_SRA;
            end
            7'h0F, 7'h73: ;
            default: ok = 0;
        endcase
        if (!ok) begin
            o.reg_write = 0; o.mem_write = 0; o.jump = 0; o.branch = 0; o.alu_src_b = 0;
            o.a_src = 0; o.res_src = 0; o.alu = 0; o.imm = 0; o.illegal = 1;
        end
        return o;
    endfunction

    task automatic tick();
        out_t nxt;
        logic [31:0] r1, r2;
        check("rs1_d", 256'(rs1_d), 256'(instr_d[19:15]));
        r1 = rf_read(instr_d[19:15]);
        r2 = rf_read(instr_d[24:20]);
        if (rst) begin
            nxt = '0;
            for (int k = 0; k < 32; k++) rf[k] = 32'h0;
        end else begin
            if (flush_e)      nxt = '0;
            else if (stall_d) nxt = exp_q;
            else              nxt = model_decode(instr_d, pc_d, pc_4_d, r1, r2);
            if (reg_write_w && rd_w != 5'd0) rf[rd_w] = result_w;
        end
        @(posedge clk);
        #1;
        exp_q = nxt;
        check("idex_bundle", 256'(dut_now()), 256'(exp_q));
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
        instr_d = ins; pc_d = pc; pc_4_d = pc + 32'd4;
    endtask

    task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] val);
        reg_write_w = we; rd_w = rd; result_w = val;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [11];
        logic [31:0] ins;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        ins = $urandom;
        if ($urandom_range(0, 9) != 0) ins[6:0] = ops[$urandom_range(0, 10)];
        if ($urandom_range(0, 2) == 0) ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        return ins;
    endfunction

    initial begin
        exp_q = '0;
        for (int k = 0; k < 32; k++) rf[k] = 32'h0;
        rst = 1; stall_d = 0; flush_e = 0;
        drive(32'h0, 32'h0);
        wb(0, 0, 0);
        tick();
        tick();
        check("reset_reg_write", 256'(reg_write_e), 256'(0));
        rst = 0;

        drive(32'h0050_0093, 32'h100);
        tick();
        check("addi_reg_write", 256'(reg_write_e), 256'(1));
        check("addi_alu_src_b", 256'(alu_src_b_e), 256'(1));
        check("addi_alu_ctrl", 256'(alu_ctrl_e), 256'(ALU_ADD));
        check("addi_imm", 256'(imm_ext_e), 256'(32'd5));
        check("addi_rd", 256'(rd_e), 256'(5'd1));

        drive(32'h0000_0013, 32'h104);
        wb(1, 5'd3, 32'hDEAD_BEEF);
        tick();
        wb(0, 0, 0);
        drive(32'h0001_8233, 32'h108);
        tick();
        check("wb_then_read", 256'(rd1_e), 256'(32'hDEAD_BEEF));

        drive(32'h0002_8333, 32'h10C);
        wb(1, 5'd5, 32'h1234_5678);
        tick();
`ifdef REGFILE_BYPASS_EN
        check("same_cycle_read", 256'(rd1_e), 256'(32'h1234_5678));
`else
        check("same_cycle_read", 256'(rd1_e), 256'(32'h0));
`endif

        drive(32'h0000_0013, 32'h110);
        wb(1, 5'd0, 32'd7);
        tick();
        wb(0, 0, 0);
        drive(32'h0000_03B3, 32'h114);
        tick();
        check("x0_read", 256'(rd1_e), 256'(32'h0));

        drive(32'hFE00_0CE3, 32'h118);
        tick();
        check("beq_branch", 256'(branch_e), 256'(1));
        check("beq_imm", 256'(imm_ext_e), 256'(32'hFFFF_FFF8));
        drive(32'h0010_00EF, 32'h11C);
        tick();
        check("jal_jump", 256'(jump_e), 256'(1));
        check("jal_res_src", 256'(result_src_e), 256'(2'b10));
        check("jal_imm", 256'(imm_ext_e), 256'(32'h0000_0800));

        drive(32'h0041_A403, 32'h120);
        tick();
        check("lw_res_src", 256'(result_src_e), 256'(2'b01));
        stall_d = 1;
        drive(32'h0050_0093, 32'h124);
        wb(1, 5'd9, 32'hCAFE_F00D);
        tick();
        wb(0, 0, 0);
        tick();
        check("stall_hold_rd1", 256'(rd1_e), 256'(32'hDEAD_BEEF));
        check("stall_hold_pc", 256'(pc_e), 256'(32'h120));
        flush_e = 1;
        tick();
        check("stall_flush_zero", 256'(dut_now()), 256'(0));
        stall_d = 0; flush_e = 0;
        drive(32'h0004_8533, 32'h128);
        tick();
        check("write_during_stall", 256'(rd1_e), 256'(32'hCAFE_F00D));

        drive(32'h0000_007F, 32'h12C);
        tick();
        check("illegal_flag", 256'(illegal_e), 256'(1));
        check("illegal_reg_write", 256'(reg_write_e), 256'(0));
        check("illegal_mem_write", 256'(mem_write_e), 256'(0));
        drive(32'h0, 32'h130);
        tick();
        check("zero_instr_legal", 256'(illegal_e), 256'(0));

        for (int n = 0; n < 400; n++) begin
            drive(rand_instr(), $urandom & 32'hFFFF_FFFC);
            wb($urandom_range(0, 1), 5'($urandom), $urandom);
            stall_d = ($urandom_range(0, 7) == 0);
            flush_e = ($urandom_range(0, 11) == 0);
            tick();
        end
        stall_d = 0; flush_e = 0;
        wb(1, 5'd3, 32'h5555_AAAA);
        drive(32'h0050_0093, 32'h200);
        tick();
        wb(0, 0, 0);

        rst = 1;
        tick();
        check("mid_rst_zero", 256'(dut_now()), 256'(0));
        rst = 0;
        drive(32'h0001_8233, 32'h204);
        tick();
        check("rst_clears_rf", 256'(rd1_e), 256'(32'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
